// File: rtl/dbpu_if.sv
// Fetch-side prediction bus of the decode-stage branch predictor: instruction
// lookup, resolved-transfer update channel and the combinational prediction result.
interface dbpu_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] inst_i;
    logic              inst_valid_i;
    logic [ADDR_W-1:0] pc_i;
    logic              stall_i;
    logic              flush_i;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_is_branch_i;
    logic              upd_is_jalr_i;
    logic              upd_taken_i;
    logic              branch_taken_o;
    logic [ADDR_W-1:0] branch_addr_o;
    logic              is_pred_branch_o;
    logic              is_pred_jalr_o;

    // Lookup fields are sampled whenever inst_valid_i=1; the update channel is a
    // one-cycle strobe (upd_valid_i) with no back-pressure, captured only when stall_i=0.
    modport master (
        output inst_i, inst_valid_i, pc_i, stall_i, flush_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_is_branch_i, upd_is_jalr_i, upd_taken_i,
        input  branch_taken_o, branch_addr_o, is_pred_branch_o, is_pred_jalr_o
    );

    modport slave (
        input  inst_i, inst_valid_i, pc_i, stall_i, flush_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_is_branch_i, upd_is_jalr_i, upd_taken_i,
        output branch_taken_o, branch_addr_o, is_pred_branch_o, is_pred_jalr_o
    );
endinterface

// File: rtl/dbpu.sv
// Decode-stage branch predictor: 2-bit BHT, direct-mapped JALR BTB and an optional
// return-address stack built only when DBPU_RAS_EN is defined.
`ifndef ITCM_BASE_ADDR
`define ITCM_BASE_ADDR 32'h8000_0000
`endif
`ifndef ITCM_SIZE
`define ITCM_SIZE 32'h0001_0000
`endif

module dbpu #(
    parameter int              ADDR_W    = 32,
    parameter int              BHT_IDX_W = 6,
    parameter int              BTB_IDX_W = 4,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ITCM_BASE = `ITCM_BASE_ADDR,
    parameter logic [ADDR_W-1:0] ITCM_SIZE = `ITCM_SIZE
) (
    input logic  clk,
    input logic  rst_n,
    dbpu_if.slave bus
);
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]        r_bht       [BHT_N];
    logic              r_btb_valid [BTB_N];
    logic [ADDR_W-1:0] r_btb_tag   [BTB_N];
    logic [ADDR_W-1:0] r_btb_tgt   [BTB_N];

    logic              r_upd_valid;
    logic [ADDR_W-1:0] r_upd_pc;
    logic [ADDR_W-1:0] r_upd_target;
    logic              r_upd_is_branch;
    logic              r_upd_is_jalr;
    logic              r_upd_taken;

    logic [31:0]       w_inst;
    logic              w_is_br, w_is_jal, w_is_jalr;
    logic [ADDR_W-1:0] w_b_imm, w_j_imm;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [BHT_IDX_W-1:0] w_bht_idx;
    logic [BTB_IDX_W-1:0] w_btb_idx;
    logic              w_btb_hit;
    logic              w_ras_hit;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_pred_taken;
    logic [ADDR_W-1:0] w_pred_tgt;
    logic              w_in_itcm;
    logic              w_apply;

    assign w_inst    = bus.inst_i[31:0];
    assign w_is_br   = bus.inst_valid_i && (w_inst[6:0] == OP_BRANCH);
    assign w_is_jal  = bus.inst_valid_i && (w_inst[6:0] == OP_JAL);
    assign w_is_jalr = bus.inst_valid_i && (w_inst[6:0] == OP_JALR) && (w_inst[14:12] == 3'b000);

    assign w_b_imm = {{(ADDR_W-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_j_imm = {{(ADDR_W-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_pc_plus4 = bus.pc_i + ADDR_W'(4);

    assign w_bht_idx = bus.pc_i[BHT_IDX_W+1:2];
    assign w_btb_idx = bus.pc_i[BTB_IDX_W+1:2];
    assign w_btb_hit = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == bus.pc_i);

    always_comb begin
        w_pred_taken = 1'b0;
        w_pred_tgt   = w_pc_plus4;
        if (w_is_br && r_bht[w_bht_idx][1]) begin
            w_pred_taken = 1'b1;
            w_pred_tgt   = bus.pc_i + w_b_imm;
        end else if (w_is_jal) begin
            w_pred_taken = 1'b1;
            w_pred_tgt   = bus.pc_i + w_j_imm;
        end else if (w_is_jalr && w_ras_hit) begin
            w_pred_taken = 1'b1;
            w_pred_tgt   = w_ras_top;
        end else if (w_is_jalr && w_btb_hit) begin
            w_pred_taken = 1'b1;
            w_pred_tgt   = r_btb_tgt[w_btb_idx];
        end
    end

    // One extra bit keeps the range check correct when the ITCM window touches the top of memory.
    assign w_in_itcm = ({1'b0, w_pred_tgt} >= {1'b0, ITCM_BASE}) &&
                       ({1'b0, w_pred_tgt} <  ({1'b0, ITCM_BASE} + {1'b0, ITCM_SIZE}));

    assign bus.branch_taken_o   = w_pred_taken && !bus.stall_i && w_in_itcm;
    assign bus.branch_addr_o    = bus.branch_taken_o ? w_pred_tgt : w_pc_plus4;
    assign bus.is_pred_branch_o = w_is_br;
    assign bus.is_pred_jalr_o   = w_is_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid     <= 1'b0;
            r_upd_pc        <= '0;
            r_upd_target    <= '0;
            r_upd_is_branch <= 1'b0;
            r_upd_is_jalr   <= 1'b0;
            r_upd_taken     <= 1'b0;
        end else if (!bus.stall_i) begin
            r_upd_valid     <= bus.upd_valid_i;
            r_upd_pc        <= bus.upd_pc_i;
            r_upd_target    <= bus.upd_target_i;
            r_upd_is_branch <= bus.upd_is_branch_i;
            r_upd_is_jalr   <= bus.upd_is_jalr_i;
            r_upd_taken     <= bus.upd_taken_i;
        end
    end

    // A held update is applied once, on the first unstalled edge after capture.
    assign w_apply = r_upd_valid && !bus.stall_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BHT_N; k++) r_bht[k] <= 2'b01;
        end else if (w_apply && r_upd_is_branch) begin
            if (r_upd_taken) begin
                if (r_bht[r_upd_pc[BHT_IDX_W+1:2]] != 2'b11)
                    r_bht[r_upd_pc[BHT_IDX_W+1:2]] <= r_bht[r_upd_pc[BHT_IDX_W+1:2]] + 2'd1;
            end else if (r_bht[r_upd_pc[BHT_IDX_W+1:2]] != 2'b00) begin
                r_bht[r_upd_pc[BHT_IDX_W+1:2]] <= r_bht[r_upd_pc[BHT_IDX_W+1:2]] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BTB_N; k++) begin
                r_btb_valid[k] <= 1'b0;
                r_btb_tag[k]   <= '0;
                r_btb_tgt[k]   <= '0;
            end
        end else if (w_apply && r_upd_is_jalr && r_upd_taken) begin
            r_btb_valid[r_upd_pc[BTB_IDX_W+1:2]] <= 1'b1;
            r_btb_tag[r_upd_pc[BTB_IDX_W+1:2]]   <= r_upd_pc;
            r_btb_tgt[r_upd_pc[BTB_IDX_W+1:2]]   <= r_upd_target;
        end
    end

`ifdef DBPU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ras_ptr;
    logic [PTR_W:0]    r_ras_cnt;
    logic [4:0]        w_rd, w_rs1;
    logic              w_rd_link, w_rs1_link, w_push, w_pop, w_ras_commit, w_ras_we;
    logic [PTR_W-1:0]  w_top_idx, w_ras_widx;

    assign w_rd         = w_inst[11:7];
    assign w_rs1        = w_inst[19:15];
    assign w_rd_link    = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link   = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_push       = (w_is_jal || w_is_jalr) && w_rd_link;
    assign w_pop        = w_is_jalr && w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
    assign w_top_idx    = r_ras_ptr - PTR_W'(1);
    assign w_ras_hit    = w_pop && (r_ras_cnt != '0);
    assign w_ras_top    = r_ras[w_top_idx];
    assign w_ras_commit = bus.inst_valid_i && !bus.stall_i && !bus.flush_i;
    // Pop-then-push collapses to overwriting the current top in place.
    assign w_ras_we     = w_ras_commit && w_push;
    assign w_ras_widx   = w_ras_hit ? w_top_idx : r_ras_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (bus.flush_i) begin
            r_ras_cnt <= '0;
        end else if (w_ras_commit) begin
            if (w_ras_hit && !w_push) begin
                r_ras_ptr <= w_top_idx;
                r_ras_cnt <= r_ras_cnt - (PTR_W+1)'(1);
            end else if (!w_ras_hit && w_push) begin
                r_ras_ptr <= r_ras_ptr + PTR_W'(1);
                if (r_ras_cnt != (PTR_W+1)'(RAS_DEPTH))
                    r_ras_cnt <= r_ras_cnt + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ras_we) r_ras[w_ras_widx] <= w_pc_plus4;
    end
`else
    logic w_unused;

    assign w_ras_hit = 1'b0;
    assign w_ras_top = '0;
    assign w_unused  = bus.flush_i;
`endif
endmodule
